// File: rtl/mem_tile_sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_tile_sram_ctrl_pkg
// Brief    : Geometry constants, OBI typedefs and FSM encoding for the
//            memory-tile SRAM controller.
// Revision : 1.0 - initial release
// ============================================================================
package mem_tile_sram_ctrl_pkg;

    localparam int unsigned NumBanksPerWord    = 8;
    localparam int unsigned NumBankRows        = 4;
    localparam int unsigned SramNumWords       = 512;
    localparam int unsigned SramDataWidth      = 64;
    localparam int unsigned AddrWidth          = 48;
    localparam int unsigned DataWidth          = NumBanksPerWord * SramDataWidth;
    localparam int unsigned IdWidth            = 4;

    localparam int unsigned SramAddrWidth      = $clog2(SramNumWords);
    localparam int unsigned SramMacroSelWidth  = (NumBankRows > 1) ? $clog2(NumBankRows) : 0;
    localparam int unsigned SramMacroSelOffset = $clog2(DataWidth / 8) + SramAddrWidth;

    typedef struct packed {
        logic [AddrWidth-1:0]   addr;
        logic                   we;
        logic [DataWidth/8-1:0] be;
        logic [DataWidth-1:0]   wdata;
        logic [IdWidth-1:0]     aid;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic [IdWidth-1:0]   rid;
        logic                 err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } init_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_tile_sram_init.sv
`default_nettype none
// ============================================================================
// Module   : mem_tile_sram_init
// Brief    : Post-reset zero-fill sequencer: sweeps every macro word once,
//            then stays in RUN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_tile_sram_init
    import mem_tile_sram_ctrl_pkg::*;
#(
    parameter int unsigned NumWords    = SramNumWords,
    parameter bit          InitOnReset = 1'b1,
    localparam int unsigned c_WORD_W   = $clog2(NumWords)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    output logic                init_active_o,
    output logic [c_WORD_W-1:0] init_addr_o,
    output logic                init_done_o
);

    init_state_e         r_state;
    logic [c_WORD_W-1:0] r_cnt;
    logic                r_done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= InitOnReset ? ST_INIT : ST_RUN;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_WORD_W'(NumWords - 1)) begin
                        r_state <= ST_RUN;
                        r_done  <= 1'b1;
                    end
                end
                default: r_done <= 1'b1;
            endcase
        end
    end

    // Qualified by rst_ni so the macros see no strobes while reset is held.
    assign init_active_o = rst_ni & (r_state == ST_INIT);
    assign init_addr_o   = r_cnt;
    assign init_done_o   = r_done;

endmodule
`default_nettype wire

// File: rtl/mem_tile_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_tile_sram_ctrl
// Brief    : OBI subordinate driving a rows x columns array of single-port
//            SRAM macros, with 1-cycle read return and post-reset zeroing.
// Revision : 1.0 - initial release
// ============================================================================
module mem_tile_sram_ctrl #(
    parameter int unsigned NumBanksPerWord = mem_tile_sram_ctrl_pkg::NumBanksPerWord,
    parameter int unsigned NumBankRows     = mem_tile_sram_ctrl_pkg::NumBankRows,
    parameter int unsigned SramNumWords    = mem_tile_sram_ctrl_pkg::SramNumWords,
    parameter int unsigned SramDataWidth   = mem_tile_sram_ctrl_pkg::SramDataWidth,
    parameter int unsigned AddrWidth       = mem_tile_sram_ctrl_pkg::AddrWidth,
    parameter int unsigned DataWidth       = mem_tile_sram_ctrl_pkg::DataWidth,
    parameter int unsigned IdWidth         = mem_tile_sram_ctrl_pkg::IdWidth,
    parameter bit          InitOnReset     = 1'b1,
    parameter type         obi_req_t       = mem_tile_sram_ctrl_pkg::obi_req_t,
    parameter type         obi_rsp_t       = mem_tile_sram_ctrl_pkg::obi_rsp_t
) (
    input  logic                                                        clk_i,
    input  logic                                                        rst_ni,
    input  obi_req_t                                                    obi_req_i,
    output obi_rsp_t                                                    obi_rsp_o,
    output logic                                                        init_done_o,
    output logic [NumBankRows-1:0][NumBanksPerWord-1:0]                 sram_req_o,
    output logic [NumBankRows-1:0][NumBanksPerWord-1:0]                 sram_we_o,
    output logic [NumBanksPerWord-1:0][$clog2(SramNumWords)-1:0]        sram_addr_o,
    output logic [NumBanksPerWord-1:0][SramDataWidth-1:0]               sram_wdata_o,
    output logic [NumBanksPerWord-1:0][SramDataWidth/8-1:0]             sram_be_o,
    input  logic [NumBankRows-1:0][NumBanksPerWord-1:0][SramDataWidth-1:0] sram_rdata_i
);

    import mem_tile_sram_ctrl_pkg::*;

    localparam int unsigned c_OFF_W  = $clog2(DataWidth / 8);
    localparam int unsigned c_WORD_W = $clog2(SramNumWords);
    localparam int unsigned c_ROW_W  = (NumBankRows > 1) ? $clog2(NumBankRows) : 1;

    logic                w_init_active;
    logic [c_WORD_W-1:0] w_init_addr;
    logic                w_init_done;
    logic                w_hs;
    logic [c_WORD_W-1:0] w_word;
    logic [c_ROW_W-1:0]  w_row;
    logic                w_unused_addr;

    logic                r_rvalid;
    logic                r_we;
    logic [IdWidth-1:0]  r_rid;
    logic [c_ROW_W-1:0]  r_row;

    mem_tile_sram_init #(
        .NumWords    (SramNumWords),
        .InitOnReset (InitOnReset)
    ) u_init (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .init_active_o (w_init_active),
        .init_addr_o   (w_init_addr),
        .init_done_o   (w_init_done)
    );

    // Grant tracks the registered done flag, so it is low out of reset.
    assign w_hs   = obi_req_i.req & w_init_done;
    assign w_word = obi_req_i.a.addr[c_OFF_W +: c_WORD_W];

    generate
        if (NumBankRows > 1) begin : g_row_dec
            assign w_row = obi_req_i.a.addr[c_OFF_W + c_WORD_W +: c_ROW_W];
        end else begin : g_row_single
            assign w_row = '0;
        end
    endgenerate

    // Address bits above the tile size alias, and the byte offset is unused.
    assign w_unused_addr = ^obi_req_i.a.addr;

    always_comb begin
        sram_req_o   = '0;
        sram_we_o    = '0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        if (w_init_active) begin
            sram_req_o = '1;
            sram_we_o  = '1;
            sram_be_o  = '1;
            for (int c = 0; c < int'(NumBanksPerWord); c++) begin
                sram_addr_o[c] = w_init_addr;
            end
        end else if (w_hs) begin
            sram_req_o[w_row] = '1;
            sram_we_o[w_row]  = {NumBanksPerWord{obi_req_i.a.we}};
            // Packed column layout matches the OBI word, so slices map 1:1.
            sram_wdata_o      = obi_req_i.a.wdata;
            sram_be_o         = obi_req_i.a.be;
            for (int c = 0; c < int'(NumBanksPerWord); c++) begin
                sram_addr_o[c] = w_word;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_we     <= 1'b0;
            r_rid    <= '0;
            r_row    <= '0;
        end else begin
            r_rvalid <= w_hs;
            if (w_hs) begin
                r_rid <= obi_req_i.a.aid;
                r_we  <= obi_req_i.a.we;
                if (!obi_req_i.a.we) begin
                    r_row <= w_row;
                end
            end
        end
    end

    always_comb begin
        obi_rsp_o          = '0;
        obi_rsp_o.gnt      = w_init_done;
        obi_rsp_o.rvalid   = r_rvalid;
        obi_rsp_o.r.rid    = r_rid;
        obi_rsp_o.r.err    = 1'b0;
        obi_rsp_o.r.rdata  = (r_rvalid && !r_we) ? sram_rdata_i[r_row] : '0;
    end

    assign init_done_o = w_init_done;

endmodule
`default_nettype wire

// File: doc/mem_tile_sram_ctrl.md
Name: mem_tile_sram_ctrl

Overview:
OBI subordinate controller for the memory-tile SRAM array. It sits directly downstream of the tile's OBI cut and directly drives the NumBankRows x NumBanksPerWord single-port SRAM macros. It provides:
- address-to-macro decoding;
- the 1-cycle read-data return path with registered row select;
- OBI response generation;
- a post-reset zero-initialisation engine, so that ECC-free macros never return X.

Parameters:
NumBanksPerWord, 8, number of macros side by side forming one OBI data word
NumBankRows, 4, number of macro rows stacked in address space
SramNumWords, 512, words per macro (power of two)
SramDataWidth, 64, bits per macro word
AddrWidth, 48, OBI address width
DataWidth, 512, OBI data width; must equal NumBanksPerWord*SramDataWidth
IdWidth, 4, OBI aid/rid width
InitOnReset, 1'b1, 1 = zero all macros after reset before granting; 0 = grant immediately
obi_req_t, logic, OBI request struct (req, a.addr, a.we, a.be, a.wdata, a.aid)
obi_rsp_t, logic, OBI response struct (gnt, rvalid, r.rdata, r.rid, r.err)

Ports:
clk_i  in  1  tile clock (gated tile clock)
rst_ni  in  1  asynchronous active-low reset
obi_req_i  in  obi_req_t  OBI request from the upstream cut
obi_rsp_o  out  obi_rsp_t  OBI response to the upstream cut
init_done_o  out  1  high once initialisation has completed and requests are accepted
sram_req_o  out  [NumBankRows][NumBanksPerWord]  per-macro request
sram_we_o  out  [NumBankRows][NumBanksPerWord]  per-macro write enable
sram_addr_o  out  [NumBanksPerWord][$clog2(SramNumWords)]  word address, shared by all rows of a column
sram_wdata_o  out  [NumBanksPerWord][SramDataWidth]  write data slice
sram_be_o  out  [NumBanksPerWord][SramDataWidth/8]  byte enables
sram_rdata_i  in  [NumBankRows][NumBanksPerWord][SramDataWidth]  macro read data, valid 1 cycle after req

Behaviour:
- Clock/reset: one clock, clk_i; asynchronous active-low reset, rst_ni. All flops reset asynchronously.
- Address decode:
  - OffW = $clog2(DataWidth/8), WordW = $clog2(SramNumWords), RowW = $clog2(NumBankRows) (0 if NumBankRows == 1).
  - word = addr[OffW +: WordW]; row = addr[OffW+WordW +: RowW].
  - Upper address bits are ignored, so the array aliases modulo tile size.
- Data slicing:
  - Column i takes wdata[i*SramDataWidth +: SramDataWidth] and be[i*SramDataWidth/8 +: SramDataWidth/8].
  - Sub-word byte enables are passed through unchanged.
- FSM states:
  - INIT: entered on reset if InitOnReset = 1.
    - A WordW-bit counter starts at 0.
    - Each cycle, every macro is driven with req = we = 1, addr = counter, be all ones, wdata 0.
    - After word SramNumWords-1 is written, go to RUN. INIT lasts exactly SramNumWords cycles.
    - gnt = 0 throughout INIT; a pending req_i is held off, not dropped.
  - RUN: entered directly on reset if InitOnReset = 0. This state is absorbing.
- init_done_o:
  - Reset value 0.
  - Registered; goes high in the first RUN cycle.
  - With InitOnReset = 0, goes high in the first cycle after reset deassertion.
- Grant:
  - In RUN, gnt = 1 combinationally whenever in RUN (independent of req).
  - Handshake is req & gnt; one request is accepted per cycle, back-to-back, with no bubbles.
- Macro strobes on handshake: only macros of the decoded row assert sram_req_o; sram_we_o = a.we on that row; all other rows idle.
- Response pipeline (registered, 1-cycle latency):
  - rvalid_q <= handshake; rid_q <= aid; row_q <= row (row_q loaded only on read handshakes); we_q <= a.we.
  - rvalid asserts exactly 1 cycle after the handshake.
  - r.rdata = we_q ? '0 : concat over columns of sram_rdata_i[row_q][i].
  - r.err = 0 always.
- Reset values: gnt 0, rvalid 0, rid 0, rdata 0, err 0, all sram_* outputs 0, init_done_o 0.
- No rready: the upstream side always accepts responses.
- Simultaneous events: a read following a write to the same word on the next cycle returns the new data (macro write-first ordering across cycles, no forwarding needed).
- Reset mid-INIT: the counter restarts at 0 and INIT runs the full SramNumWords cycles again.
- Reset mid-RUN: any in-flight response is discarded; rvalid is 0 after reset.

Decomposition:
- The shared picobello package holds NumBanksPerWord, NumBankRows, SramNumWords, SramDataWidth and derived SramAddrWidth / SramMacroSelWidth / SramMacroSelOffset.
- The OBI typedefs come from the tile's SbrObiCfg.
- One sub-module, mem_tile_sram_init: the counter/FSM producing init_active, init_addr and init_done. The controller muxes between init drive and OBI drive.

Test Plan:
- Init zeroing: InitOnReset = 1, SramNumWords = 512, req held high from reset → gnt = 0 for exactly 512 cycles; every macro written at addr 0..511 with be all ones and data 0; init_done_o rises in cycle 513; first read of addr 0x0 returns rdata 0, rid = aid.
- Row decode: write 0xA5 pattern, be all ones, to word 3 / row 2 (addr = (2*512+3)*64) → only sram_req_o[2][*] active; read-back 1 cycle later → rdata = pattern, and rows 0, 1, 3 are never strobed.
- Back-to-back reads: reads to rows 0, 1, 2, 3 on consecutive cycles, aid 0..3 → rvalid high 4 consecutive cycles; rid 0..3 in order, each rdata from the correct row.
- Partial write: write be = 0x0000_0000_0000_00FF (byte lanes 0-7 only), wdata all ones, onto a zeroed word → only column 0 has be = 0xFF; readback shows lowest 64 bits set, rest 0; write response has rvalid with rdata 0 and err 0.
- Reset mid-init: assert rst_ni low at INIT cycle 200, release → counter restarts at 0; init_done_o rises after 512 more cycles.
- Write-then-read same word: write cycle N, read cycle N+1, same address → read returns the new data at cycle N+2.
